// File: rtl/m_div_controller_if.sv
// M-unit divider core-side bus: dispatch request (start) and writeback result channels.
// Latency: none, wires only.
// Backpressure: start_ready gates dispatch; result_ready holds the result until taken.
interface m_div_controller_if #(
  parameter int XLEN = 32
);
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;

  // Core side: issues requests, consumes results.
  modport master (
    output start_valid, op, rs1, rs2, result_ready,
    input  start_ready, result_valid, result
  );

  // Divider side: accepts requests, produces results.
  modport slave (
    input  start_valid, op, rs1, rs2, result_ready,
    output start_ready, result_valid, result
  );
endinterface

// File: rtl/m_div_controller.sv
// Control FSM for the iterative restoring divider (DIV/DIVU/REM/REMU, RISC-V special cases).
// Latency: 34 edges accept->result_valid for normal ops, 1 edge for div-by-zero/overflow.
// Backpressure: one op in flight, start_ready only in IDLE; result held in DONE until result_ready.
module m_div_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             reset,
  m_div_controller_if.slave bus,
  output logic [XLEN-1:0]  dp_rs1_o,
  output logic [XLEN-1:0]  dp_rs2_o,
  output logic [1:0]       mux_r_o,
  output logic [1:0]       mux_d_o,
  output logic [1:0]       mux_z_o,
  input  logic [XLEN-1:0]  r_i,
  input  logic [XLEN-1:0]  z_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] R_KEEP = 2'd0, R_A = 2'd1, R_A_NEG = 2'd2, R_SUB_KEEP = 2'd3;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_rem_q, op_rem_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [XLEN-1:0]  dp_rs1_q, dp_rs1_d;
  logic [XLEN-1:0]  dp_rs2_q, dp_rs2_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic            accept;
  logic            is_signed;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Request decode: handshake and the two short-circuit cases resolved at accept time.
  always_comb begin
    accept      = bus.start_valid && (state_q == S_IDLE);
    is_signed   = ~bus.op[0];
    div_zero    = (bus.rs2 == '0);
    overflow    = is_signed && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = bus.op[1] ? bus.rs1 : '1;
    end else begin
      special_res = bus.op[1] ? '0 : INT_MIN;
    end
  end

  // Sign fix-up: quotient negative when operand signs differ, remainder takes the dividend sign.
  always_comb begin
    quo_fix = (neg_a_q ^ neg_b_q) ? ('0 - z_i) : z_i;
    rem_fix = neg_a_q ? ('0 - r_i) : r_i;
  end

  // Next-state logic for the sequencer and its captured operands/result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_rem_d = op_rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dp_rs1_d = dp_rs1_q;
    dp_rs2_d = dp_rs2_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_rem_d = bus.op[1];
          neg_a_d  = is_signed && bus.rs1[XLEN-1];
          neg_b_d  = is_signed && bus.rs2[XLEN-1];
          dp_rs1_d = bus.rs1;
          dp_rs2_d = bus.rs2;
          if (div_zero || overflow) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_INIT;
          end
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        // Counter returns to 0 on exit so it is clean for the next op.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIXUP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_FIXUP: begin
        result_d = op_rem_q ? rem_fix : quo_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_rem_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dp_rs1_q <= '0;
      dp_rs2_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_rem_q <= op_rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dp_rs1_q <= dp_rs1_d;
      dp_rs2_q <= dp_rs2_d;
      result_q <= result_d;
    end
  end

  // Datapath mux selects decoded from state; KEEP everywhere outside INIT/ITER.
  always_comb begin
    mux_r_o = R_KEEP;
    mux_d_o = D_KEEP;
    mux_z_o = Z_KEEP;
    case (state_q)
      S_INIT: begin
        mux_r_o = neg_a_q ? R_A_NEG : R_A;
        mux_d_o = neg_b_q ? D_B_NEG : D_B;
        mux_z_o = Z_ZERO;
      end
      S_ITER: begin
        mux_r_o = R_SUB_KEEP;
        mux_d_o = D_SHR;
        mux_z_o = Z_SHL_ADD;
      end
      default: begin
        mux_r_o = R_KEEP;
        mux_d_o = D_KEEP;
        mux_z_o = Z_KEEP;
      end
    endcase
  end

  // Output drive: handshake flags from state, operands and result from registers.
  always_comb begin
    bus.start_ready  = (state_q == S_IDLE);
    bus.result_valid = (state_q == S_DONE);
    bus.result       = result_q;
    dp_rs1_o         = dp_rs1_q;
    dp_rs2_o         = dp_rs2_q;
  end

endmodule

// File: tb/tb_m_div_controller.sv
// Directed bench for m_div_controller with a behavioural R/D/Z restoring-divider datapath.
// Latency: checks 34-edge normal and 1-edge special-case result timing.
// Backpressure: exercises result_ready hold in DONE and start_valid ignored while busy.
module tb_m_div_controller;

  logic clk;
  logic reset;
  logic [31:0] dp_rs1, dp_rs2;
  logic [1:0]  mux_r, mux_d, mux_z;
  logic [31:0] dr, dz;
  logic [62:0] dd;
  int vectors;
  int fails;

  m_div_controller_if #(.XLEN(32)) sif ();

  m_div_controller #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (sif.slave),
    .dp_rs1_o (dp_rs1),
    .dp_rs2_o (dp_rs2),
    .mux_r_o  (mux_r),
    .mux_d_o  (mux_d),
    .mux_z_o  (mux_z),
    .r_i      (dr),
    .z_i      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider datapath: R remainder, D shifted divisor (63 bits), Z quotient.
  always @(posedge clk) begin
    case (mux_r)
      2'd1: dr <= dp_rs1;
      2'd2: dr <= 32'd0 - dp_rs1;
      2'd3: if ({31'd0, dr} >= dd) dr <= dr - dd[31:0];
      default: dr <= dr;
    endcase
    case (mux_d)
      2'd1: dd <= {dp_rs2, 31'd0};
      2'd2: dd <= {32'd0 - dp_rs2, 31'd0};
      2'd3: dd <= dd >> 1;
      default: dd <= dd;
    endcase
    case (mux_z)
      2'd1: dz <= 32'd0;
      2'd2: dz <= {dz[30:0], ({31'd0, dr} >= dd)};
      default: dz <= dz;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, count edges to result_valid, check result, then retire it.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    bit got;
    @(negedge clk);
    chk({tag, "_start_ready"}, {31'd0, sif.start_ready}, 32'd1);
    sif.start_valid = 1'b1;
    sif.op          = op;
    sif.rs1         = a;
    sif.rs2         = b;
    @(posedge clk);
    #1;
    sif.start_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sif.result_valid === 1'b1) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_result"}, sif.result, exp);
    sif.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.result_ready = 1'b0;
    chk({tag, "_retired"}, {30'd0, sif.result_valid, sif.start_ready}, 32'd1);
  endtask

  initial begin
    vectors          = 0;
    fails            = 0;
    dr               = 32'd0;
    dd               = 63'd0;
    dz               = 32'd0;
    reset            = 1'b1;
    sif.start_valid  = 1'b0;
    sif.op           = 2'd0;
    sif.rs1          = 32'd0;
    sif.rs2          = 32'd0;
    sif.result_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_result_valid", {31'd0, sif.result_valid}, 32'd0);
    chk("rst_result", sif.result, 32'd0);
    chk("rst_dp", dp_rs1 | dp_rs2, 32'd0);
    chk("rst_mux", {26'd0, mux_r, mux_d, mux_z}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_start_ready", {31'd0, sif.start_ready}, 32'd1);

    // Unsigned normal path.
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34);

    // Signed normal path with sign fix-up.
    do_op("div_m7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("div_7_m2",  2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    do_op("rem_7_m2",  2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

    // Divide by zero short-circuits.
    do_op("div_5_0",   2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem_5_0",   2'b10, 32'd5, 32'd0, 32'd5, 1);
    do_op("divu_0_0",  2'b01, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);

    // Signed overflow short-circuits; unsigned with the same operands runs fully:
    // 2^31 / (2^32-1) = 0 remainder 2^31.
    do_op("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("divu_ovf",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    do_op("remu_ovf",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

    // Writeback backpressure: result held while result_ready is low, new requests ignored.
    @(negedge clk);
    sif.start_valid = 1'b1;
    sif.op          = 2'b01;
    sif.rs1         = 32'd100;
    sif.rs2         = 32'd7;
    @(posedge clk);
    #1;
    sif.rs1 = 32'd55;
    sif.rs2 = 32'd5;
    repeat (34) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", sif.result, 32'd14);
      chk("hold_flags", {30'd0, sif.result_valid, sif.start_ready}, 32'd2);
      @(posedge clk);
    end
    @(negedge clk);
    sif.start_valid  = 1'b0;
    sif.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.result_ready = 1'b0;
    chk("hold_release", {30'd0, sif.result_valid, sif.start_ready}, 32'd1);
    do_op("divu_55_5", 2'b01, 32'd55, 32'd5, 32'd11, 34);

    // Reset during ITER cycle 10 of a signed op.
    @(negedge clk);
    sif.start_valid = 1'b1;
    sif.op          = 2'b00;
    sif.rs1         = 32'hFFFF_FF9C;
    sif.rs2         = 32'd7;
    @(posedge clk);
    #1;
    sif.start_valid = 1'b0;
    @(negedge clk);
    chk("init_mux", {26'd0, mux_r, mux_d, mux_z}, {26'd0, 2'd2, 2'd1, 2'd1});
    chk("init_dp_rs1", dp_rs1, 32'hFFFF_FF9C);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("iter_mux", {26'd0, mux_r, mux_d, mux_z}, {26'd0, 2'd3, 2'd3, 2'd2});
    reset = 1'b1;
    #1;
    chk("midrst_mux", {26'd0, mux_r, mux_d, mux_z}, 32'd0);
    chk("midrst_dp", dp_rs1 | dp_rs2, 32'd0);
    chk("midrst_result", sif.result, 32'd0);
    chk("midrst_flags", {30'd0, sif.result_valid, sif.start_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_valid", {31'd0, sif.result_valid}, 32'd0);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
